// File: rtl/conv_ofm_pack_writer.sv
// Steps the 4:1 pipeline mux over one pixel's channel groups and writes them to the next-stage BRAM.
// Optional OFM_PINGPONG_EN: alternate frames between two BRAM banks.
module conv_ofm_pack_writer #(
  parameter int NUM_GROUPS = 4,
  parameter int PIXELS     = 2916,
  parameter int ADDR_W     = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          done_window,
  output logic [$clog2(NUM_GROUPS)-1:0] control_mux,
  output logic                          wr_en_next,
  output logic [ADDR_W-1:0]             addr_ram_next_wr,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(PIXELS+1)-1:0]   pixel_count,
  output logic                          overflow_err,
  output logic                          bank_sel
);

  localparam int GW  = $clog2(NUM_GROUPS);
  localparam int PCW = $clog2(PIXELS + 1);
  localparam logic [GW-1:0]     LAST_G   = GW'(NUM_GROUPS - 1);
  localparam logic [PCW-1:0]    LAST_PIX = PCW'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      g, g_nxt;
  logic               armed, armed_nxt;
  logic               pending, pending_nxt;
  logic [PCW-1:0]     pc_nxt;
  logic               ovf_nxt;
  logic [ADDR_W-1:0]  wr_addr, wr_addr_nxt;
  logic [ADDR_W-1:0]  base_nxt;

`ifdef OFM_PINGPONG_EN
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(PIXELS * NUM_GROUPS);
  logic bank_q, bank_nxt;

  // Bank flips as DONE retires, even if a frame_start lands on that same cycle.
  assign bank_nxt = (state == DONE) ? ~bank_q : bank_q;
  assign base_nxt = BASE + (bank_nxt ? SPAN : '0);
  assign bank_sel = bank_q;

  always_ff @(posedge clk) begin
    if (reset) bank_q <= 1'b0;
    else       bank_q <= bank_nxt;
  end
`else
  assign base_nxt = BASE;
  assign bank_sel = 1'b0;
`endif

  assign busy = (state == WRITE) | pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      g            <= '0;
      armed        <= 1'b0;
      pending      <= 1'b0;
      pixel_count  <= '0;
      overflow_err <= 1'b0;
      wr_addr      <= BASE;
    end else begin
      state        <= state_nxt;
      g            <= g_nxt;
      armed        <= armed_nxt;
      pending      <= pending_nxt;
      pixel_count  <= pc_nxt;
      overflow_err <= ovf_nxt;
      wr_addr      <= wr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    g_nxt            = g;
    armed_nxt        = armed;
    pending_nxt      = pending;
    pc_nxt           = pixel_count;
    ovf_nxt          = overflow_err;
    wr_addr_nxt      = wr_addr;
    wr_en_next       = 1'b0;
    control_mux      = '0;
    addr_ram_next_wr = '0;
    frame_done       = (state == DONE);

    if (frame_start) begin
      // Abort whatever is in flight; no write is issued this cycle.
      state_nxt   = IDLE;
      g_nxt       = '0;
      armed_nxt   = 1'b1;
      pending_nxt = 1'b0;
      pc_nxt      = '0;
      ovf_nxt     = 1'b0;
      wr_addr_nxt = base_nxt;
    end else begin
      unique case (state)
        IDLE: begin
          if (armed && (done_window || pending)) begin
            state_nxt   = WRITE;
            g_nxt       = '0;
            // A consumed pending slot is immediately refilled by a coincident pixel.
            pending_nxt = pending & done_window;
          end
        end
        WRITE: begin
          wr_en_next       = 1'b1;
          control_mux      = g;
          addr_ram_next_wr = wr_addr;
          wr_addr_nxt      = wr_addr + ADDR_W'(1);
          if (g == LAST_G) begin
            g_nxt  = '0;
            pc_nxt = pixel_count + PCW'(1);
            if (pixel_count == LAST_PIX) begin
              state_nxt = DONE;
              if (done_window) ovf_nxt = 1'b1;
            end else if (pending || done_window) begin
              pending_nxt = pending & done_window;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            g_nxt = g + GW'(1);
            if (done_window) begin
              if (pending) ovf_nxt = 1'b1;
              else         pending_nxt = 1'b1;
            end
          end
        end
        DONE: begin
          state_nxt   = IDLE;
          armed_nxt   = 1'b0;
          pending_nxt = 1'b0;
          if (done_window) ovf_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ofm_pack_writer.sv
// Directed bench for conv_ofm_pack_writer with a 4-pixel frame.
module tb_conv_ofm_pack_writer;

  localparam int NG = 4;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        done_window = 1'b0;
  logic [1:0]  control_mux;
  logic        wr_en_next;
  logic [31:0] addr_ram_next_wr;
  logic        busy;
  logic        frame_done;
  logic [2:0]  pixel_count;
  logic        overflow_err;
  logic        bank_sel;

  conv_ofm_pack_writer #(
    .NUM_GROUPS(NG), .PIXELS(NP), .ADDR_W(32), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .done_window(done_window),
    .control_mux(control_mux), .wr_en_next(wr_en_next), .addr_ram_next_wr(addr_ram_next_wr),
    .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count),
    .overflow_err(overflow_err), .bank_sel(bank_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wm_q[$];
  int          wc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_next) begin
      wa_q.push_back(addr_ram_next_wr);
      wm_q.push_back(32'(control_mux));
      wc_q.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // n pixels, one done_window every NG cycles, then drain.
  task automatic run_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      done_window = 1'b1;
      step();
      done_window = 1'b0;
      repeat (NG - 1) step();
    end
    repeat (6) step();
  endtask

  task automatic clear_log();
    wa_q.delete();
    wm_q.delete();
    wc_q.delete();
  endtask

  task automatic check_writes(input string tag, input int n, input int base);
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, wa_q[i], 32'(base + i));
      chk({tag, "_mux"}, wm_q[i], 32'(i % NG));
    end
  endtask

  int exp_base2;

  initial begin
    // Reset state
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en_next), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", 32'(pixel_count), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_mux", 32'(control_mux), 0);
    chk("rst_addr", addr_ram_next_wr, 0);
    chk("rst_bank", 32'(bank_sel), 0);

    // Unarmed done_window is ignored
    step();
    done_window = 1'b1;
    step();
    done_window = 1'b0;
    repeat (4) step();
    chk("unarmed_nwr", 32'(wa_q.size()), 0);
    chk("unarmed_ovf", 32'(overflow_err), 0);

    // 1: single pixel, latency and busy
    start_frame();
    clear_log();
    done_window = 1'b1;
    step();
    done_window = 1'b0;
    @(negedge clk);
    chk("t1_first_wr", 32'(wr_en_next), 1);
    chk("t1_busy", 32'(busy), 1);
    step(); step(); step();
    @(negedge clk);
    chk("t1_last_addr", addr_ram_next_wr, 3);
    chk("t1_busy_last", 32'(busy), 1);
    step();
    @(negedge clk);
    chk("t1_wr_off", 32'(wr_en_next), 0);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_mux_off", 32'(control_mux), 0);
    chk("t1_pc", 32'(pixel_count), 1);
    check_writes("t1", 4, 0);

    // 2: three back-to-back pixels
    start_frame();
    clear_log();
    run_pixels(3);
    check_writes("t2", 12, 0);
    if (wc_q.size() == 12) chk("t2_gapless", 32'(wc_q[11] - wc_q[0]), 11);
    chk("t2_pc", 32'(pixel_count), 3);

    // 3: pending accepted at g=1, second at g=2 overflows
    start_frame();
    clear_log();
    done_window = 1'b1; step();
    done_window = 1'b0; step();
    done_window = 1'b1; step();
    step();
    done_window = 1'b0;
    repeat (8) step();
    check_writes("t3", 8, 0);
    chk("t3_ovf", 32'(overflow_err), 1);
    chk("t3_pc", 32'(pixel_count), 2);

    // 4: full frame, frame_done once, later pixels ignored
    start_frame();
    clear_log();
    run_pixels(NP);
    check_writes("t4", 16, 0);
    chk("t4_fd_cnt", 32'(fd_cnt), 1);
    if (wc_q.size() == 16) chk("t4_fd_cyc", 32'(fd_cyc - wc_q[15]), 1);
    chk("t4_pc", 32'(pixel_count), NP);
    chk("t4_ovf", 32'(overflow_err), 0);
    clear_log();
    run_pixels(1);
    chk("t4_ignored_nwr", 32'(wa_q.size()), 0);
    chk("t4_pc_hold", 32'(pixel_count), NP);
    chk("t4_fd_cnt2", 32'(fd_cnt), 1);
    chk("t4_busy", 32'(busy), 0);

    // 5: second frame bank, third frame back at bank 0
`ifdef OFM_PINGPONG_EN
    chk("t5_bank1", 32'(bank_sel), 1);
    exp_base2 = NP * NG;
`else
    chk("t5_bank1", 32'(bank_sel), 0);
    exp_base2 = 0;
`endif
    start_frame();
    clear_log();
    run_pixels(NP);
    check_writes("t5f2", 16, exp_base2);
    chk("t5_bank2", 32'(bank_sel), 0);
    chk("t5_fd_cnt", 32'(fd_cnt), 2);
    start_frame();
    clear_log();
    run_pixels(1);
    check_writes("t5f3", 4, 0);

    // 6: frame_start at g=2 aborts and clears the error
    start_frame();
    clear_log();
    done_window = 1'b1; step();
    step();
    step();
    done_window = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    chk("t6_ovf_before", 32'(overflow_err), 1);
    chk("t6_no_wr", 32'(wr_en_next), 0);
    step();
    frame_start = 1'b0;
    @(negedge clk);
    chk("t6_pc", 32'(pixel_count), 0);
    chk("t6_ovf", 32'(overflow_err), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_nwr_abort", 32'(wa_q.size()), 2);
    clear_log();
    run_pixels(1);
    check_writes("t6", 4, 0);
    chk("t6_pc_after", 32'(pixel_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
